// File: rtl/clock_mode_ctrl.sv
// clock_mode_ctrl: time-setting mode controller for a 24h clock.
// Freezes the second tick while the user edits hours/minutes, then
// issues a one-cycle load strobe to the time counter on commit.
// Abandons an edit after TIMEOUT_S idle seconds.
// Optional build macro CLOCK_ALARM_EN adds alarm-time edit states,
// alarm registers and the alarm_ring output.
module clock_mode_ctrl #(
  parameter int unsigned TIMEOUT_S = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [4:0] cur_hours,
  input  logic [5:0] cur_minutes,
  output logic       tick_en,
  output logic       load,
  output logic [4:0] load_hours,
  output logic [5:0] load_minutes,
  output logic [1:0] edit_field,
`ifdef CLOCK_ALARM_EN
  output logic       blink,
  output logic       alarm_ring
`else
  output logic       blink
`endif
);

  typedef enum logic [2:0] {
    ST_RUN    = 3'd0,
    ST_SET_H  = 3'd1,
    ST_SET_M  = 3'd2,
`ifdef CLOCK_ALARM_EN
    ST_SET_AH = 3'd4,
    ST_SET_AM = 3'd5,
`endif
    ST_COMMIT = 3'd3
  } state_t;

  state_t     r_state;
  state_t     w_next_state;
  logic [4:0] r_edit_h;
  logic [5:0] r_edit_m;
  logic [7:0] r_idle;
  logic       r_blink;

  logic       w_btn;
  logic       w_inc;
  logic       w_editing;
  logic       w_next_editing;
  logic       w_timeout;
  logic       w_consume;

`ifdef CLOCK_ALARM_EN
  logic [4:0] r_edit_ah;
  logic [5:0] r_edit_am;
  logic [4:0] r_alarm_h;
  logic [5:0] r_alarm_m;
  logic       r_match_d;
  logic       r_alarm_ring;
  logic       w_match;
`endif

  // Button qualification, idle timeout and alarm-clear consumption
  always_comb begin
    w_btn     = btn_mode | btn_inc;
    // btn_mode has priority: a simultaneous btn_inc is dropped
    w_inc     = btn_inc & ~btn_mode;
    w_editing = (r_state == ST_SET_H) || (r_state == ST_SET_M)
`ifdef CLOCK_ALARM_EN
             || (r_state == ST_SET_AH) || (r_state == ST_SET_AM)
`endif
             ;
    w_timeout = w_editing & tick_1hz & ~w_btn
              & (r_idle == 8'(TIMEOUT_S - 1));
`ifdef CLOCK_ALARM_EN
    w_match   = (cur_hours == r_alarm_h) && (cur_minutes == r_alarm_m);
    // a button that silences the alarm does nothing else
    w_consume = (r_state == ST_RUN) & r_alarm_ring & w_btn;
`else
    w_consume = 1'b0;
`endif
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_RUN:    if (btn_mode && !w_consume) w_next_state = ST_SET_H;
      ST_SET_H:  if (btn_mode)      w_next_state = ST_SET_M;
                 else if (w_timeout) w_next_state = ST_RUN;
`ifdef CLOCK_ALARM_EN
      ST_SET_M:  if (btn_mode)      w_next_state = ST_SET_AH;
                 else if (w_timeout) w_next_state = ST_RUN;
      ST_SET_AH: if (btn_mode)      w_next_state = ST_SET_AM;
                 else if (w_timeout) w_next_state = ST_RUN;
      ST_SET_AM: if (btn_mode)      w_next_state = ST_COMMIT;
                 else if (w_timeout) w_next_state = ST_RUN;
`else
      ST_SET_M:  if (btn_mode)      w_next_state = ST_COMMIT;
                 else if (w_timeout) w_next_state = ST_RUN;
`endif
      ST_COMMIT: w_next_state = ST_RUN;
      default:   w_next_state = ST_RUN;
    endcase
    w_next_editing = (w_next_state == ST_SET_H) || (w_next_state == ST_SET_M)
`ifdef CLOCK_ALARM_EN
                  || (w_next_state == ST_SET_AH) || (w_next_state == ST_SET_AM)
`endif
                  ;
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_RUN;
    else       r_state <= w_next_state;
  end

  // Edit value registers: snapshot on entry, wrap-increment per field
  always_ff @(posedge clk) begin
    if (reset) begin
      r_edit_h <= '0;
      r_edit_m <= '0;
    end else if (r_state == ST_RUN && btn_mode && !w_consume) begin
      r_edit_h <= cur_hours;
      r_edit_m <= cur_minutes;
    end else if (r_state == ST_SET_H && w_inc) begin
      r_edit_h <= (r_edit_h == 5'd23) ? '0 : r_edit_h + 5'd1;
    end else if (r_state == ST_SET_M && w_inc) begin
      r_edit_m <= (r_edit_m == 6'd59) ? '0 : r_edit_m + 6'd1;
    end
  end

  // Idle counter: restarts on any press or state change, counts seconds while editing
  always_ff @(posedge clk) begin
    if (reset)                                  r_idle <= '0;
    else if (w_btn || w_next_state != r_state)  r_idle <= '0;
    else if (w_editing && tick_1hz)             r_idle <= r_idle + 8'd1;
  end

  // Blink phase: on at field entry, toggles each second, off outside edits
  always_ff @(posedge clk) begin
    if (reset)                        r_blink <= 1'b0;
    else if (!w_next_editing)         r_blink <= 1'b0;
    else if (w_next_state != r_state) r_blink <= 1'b1;
    else if (tick_1hz)                r_blink <= ~r_blink;
  end

`ifdef CLOCK_ALARM_EN
  // Alarm edit copies and committed alarm time
  always_ff @(posedge clk) begin
    if (reset) begin
      r_edit_ah <= '0;
      r_edit_am <= '0;
      r_alarm_h <= '0;
      r_alarm_m <= '0;
    end else begin
      if (r_state == ST_RUN && btn_mode && !w_consume) begin
        r_edit_ah <= r_alarm_h;
        r_edit_am <= r_alarm_m;
      end else if (r_state == ST_SET_AH && w_inc) begin
        r_edit_ah <= (r_edit_ah == 5'd23) ? '0 : r_edit_ah + 5'd1;
      end else if (r_state == ST_SET_AM && w_inc) begin
        r_edit_am <= (r_edit_am == 6'd59) ? '0 : r_edit_am + 6'd1;
      end
      if (r_state == ST_COMMIT) begin
        r_alarm_h <= r_edit_ah;
        r_alarm_m <= r_edit_am;
      end
    end
  end

  // Alarm ring: set on rising match edge in RUN, cleared by any button in RUN
  always_ff @(posedge clk) begin
    if (reset) begin
      r_match_d    <= 1'b0;
      r_alarm_ring <= 1'b0;
    end else begin
      r_match_d <= w_match;
      if (r_state == ST_RUN && w_btn)
        r_alarm_ring <= 1'b0;
      else if (r_state == ST_RUN && w_match && !r_match_d)
        r_alarm_ring <= 1'b1;
    end
  end

  assign alarm_ring = r_alarm_ring;
`endif

  // Output decode
  always_comb begin
    tick_en      = tick_1hz & (r_state == ST_RUN);
    load         = (r_state == ST_COMMIT);
    load_hours   = r_edit_h;
    load_minutes = r_edit_m;
    blink        = r_blink;
    edit_field   = 2'b00;
    unique case (r_state)
      ST_SET_H:  edit_field = 2'b01;
      ST_SET_M:  edit_field = 2'b10;
`ifdef CLOCK_ALARM_EN
      ST_SET_AH: edit_field = 2'b11;
      ST_SET_AM: edit_field = 2'b11;
`endif
      default:   edit_field = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Directed testbench for clock_mode_ctrl (alarm section built only
// when CLOCK_ALARM_EN is defined).
module tb_clock_mode_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick_1hz;
  logic       btn_mode;
  logic       btn_inc;
  logic [4:0] cur_hours;
  logic [5:0] cur_minutes;
  logic       tick_en;
  logic       load;
  logic [4:0] load_hours;
  logic [5:0] load_minutes;
  logic [1:0] edit_field;
  logic       blink;
`ifdef CLOCK_ALARM_EN
  logic       alarm_ring;
`endif

  int checks = 0;
  int errors = 0;

  clock_mode_ctrl #(.TIMEOUT_S(30)) dut (
    .clk          (clk),
    .reset        (reset),
    .tick_1hz     (tick_1hz),
    .btn_mode     (btn_mode),
    .btn_inc      (btn_inc),
    .cur_hours    (cur_hours),
    .cur_minutes  (cur_minutes),
    .tick_en      (tick_en),
    .load         (load),
    .load_hours   (load_hours),
    .load_minutes (load_minutes),
    .edit_field   (edit_field),
`ifdef CLOCK_ALARM_EN
    .blink        (blink),
    .alarm_ring   (alarm_ring)
`else
    .blink        (blink)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // advance one clock; sample point is 1ns after the edge, pulses cleared
  task automatic cyc();
    @(posedge clk);
    #1;
    tick_1hz = 1'b0;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
  endtask

  task automatic press_mode();
    btn_mode = 1'b1;
    cyc();
  endtask

  task automatic press_inc();
    btn_inc = 1'b1;
    cyc();
  endtask

  task automatic tick1(input string tag, input logic exp_tick_en);
    tick_1hz = 1'b1;
    #1;
    check(tag, tick_en, exp_tick_en);
    cyc();
  endtask

  initial begin
    reset = 1'b1; tick_1hz = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
    cur_hours = 5'd22; cur_minutes = 6'd58;
    cyc(); cyc();
    check("rst_field", edit_field, 2'b00);
    check("rst_load", load, 1'b0);
    check("rst_blink", blink, 1'b0);
    check("rst_h", load_hours, 5'd0);
    check("rst_m", load_minutes, 6'd0);
    reset = 1'b0;

    // free-running: ticks pass through
    for (int i = 0; i < 3; i++) begin
      tick1("run_tick_en", 1'b1);
      check("run_load", load, 1'b0);
      check("run_field", edit_field, 2'b00);
    end

    // full edit 22:58 -> 01:00
    press_mode();
    check("seth_field", edit_field, 2'b01);
    check("seth_snap_h", load_hours, 5'd22);
    check("seth_snap_m", load_minutes, 6'd58);
    check("seth_blink_on", blink, 1'b1);
    tick1("seth_gated", 1'b0);
    check("seth_blink_tog", blink, 1'b0);
    press_inc(); press_inc(); press_inc();
    check("seth_wrap", load_hours, 5'd1);
    press_mode();
    check("setm_field", edit_field, 2'b10);
    check("setm_blink_on", blink, 1'b1);
    press_inc(); press_inc();
    check("setm_wrap", load_minutes, 6'd0);
`ifdef CLOCK_ALARM_EN
    press_mode();
    check("setah_field", edit_field, 2'b11);
    press_mode();
    check("setam_field", edit_field, 2'b11);
`endif
    press_mode();
    check("commit_load", load, 1'b1);
    check("commit_h", load_hours, 5'd1);
    check("commit_m", load_minutes, 6'd0);
    check("commit_field", edit_field, 2'b00);
    cyc();
    check("post_load", load, 1'b0);
    check("post_field", edit_field, 2'b00);
    tick1("post_tick_en", 1'b1);

    // simultaneous mode+inc in SET_H: mode wins
    press_mode();
    check("pri_seth", edit_field, 2'b01);
    btn_mode = 1'b1; btn_inc = 1'b1;
    cyc();
    check("pri_field", edit_field, 2'b10);
    check("pri_h", load_hours, 5'd22);

    // timeout in SET_M after 30 idle ticks
    for (int i = 0; i < 29; i++) begin
      tick1("to_gated", 1'b0);
      check("to_noload", load, 1'b0);
    end
    check("to_29_field", edit_field, 2'b10);
    tick1("to_30_gated", 1'b0);
    check("to_30_field", edit_field, 2'b00);
    check("to_30_load", load, 1'b0);
    cyc();
    check("to_after_load", load, 1'b0);
    tick1("to_after_tick", 1'b1);

    // button press restarts the idle count
    press_mode();
    for (int i = 0; i < 20; i++) tick1("idle_gated", 1'b0);
    press_inc();
    for (int i = 0; i < 29; i++) tick1("idle2_gated", 1'b0);
    check("idle_29_field", edit_field, 2'b01);
    tick1("idle_30_gated", 1'b0);
    check("idle_30_field", edit_field, 2'b00);
    check("idle_30_load", load, 1'b0);

    // btn_inc in RUN is ignored
    press_inc();
    check("runinc_field", edit_field, 2'b00);
    check("runinc_load", load, 1'b0);

    // reset mid-edit with btn_mode in the same cycle
    press_mode(); press_mode();
    check("rst2_pre", edit_field, 2'b10);
    reset = 1'b1; btn_mode = 1'b1;
    cyc();
    check("rst2_field", edit_field, 2'b00);
    check("rst2_load", load, 1'b0);
    check("rst2_h", load_hours, 5'd0);
    check("rst2_m", load_minutes, 6'd0);
    check("rst2_blink", blink, 1'b0);
    reset = 1'b0;
    cyc();
    check("rst2_after_load", load, 1'b0);

`ifdef CLOCK_ALARM_EN
    // set alarm to 07:00 and trigger it
    cur_hours = 5'd6; cur_minutes = 6'd59;
    press_mode(); press_mode(); press_mode();
    for (int i = 0; i < 7; i++) press_inc();
    press_mode(); press_mode();
    check("al_commit", load, 1'b1);
    cyc();
    check("al_idle", alarm_ring, 1'b0);
    cur_hours = 5'd7; cur_minutes = 6'd0;
    cyc();
    check("al_ring", alarm_ring, 1'b1);
    press_mode();
    check("al_clear", alarm_ring, 1'b0);
    check("al_consumed", edit_field, 2'b00);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
